// File: rtl/axi4_mem_pkg.sv
// Shared types, response codes and address helpers for the AXI4 burst memory slave.
package axi4_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  function automatic logic [63:0] addr_to_index(input logic [63:0] addr,
                                                input logic [63:0] base,
                                                input int unsigned nb_log2);
    return (addr - base) >> nb_log2;
  endfunction

  // Below-base addresses would wrap the subtraction, so they are rejected first.
  function automatic logic beat_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input int unsigned nb_log2,
                                         input logic [63:0] depth);
    return (addr >= base) && (addr_to_index(addr, base, nb_log2) < depth);
  endfunction

endpackage

// File: rtl/axi4_mem_array.sv
// Word array with one byte-strobed synchronous write port and one combinational read port.
module axi4_mem_array
  import axi4_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [DATA_WIDTH/8-1:0]    wstrb,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]      rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Byte-lane write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb[b]) begin
          mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 INCR-burst memory slave: independent write and read FSMs around a byte-strobed word array.
module axi4_burst_mem_slave
  import axi4_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4096,
  parameter int                    RD_LATENCY = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast
);

  localparam int                    NB        = DATA_WIDTH / 8;
  localparam int unsigned           NB_LOG2   = $clog2(NB);
  localparam int                    IDX_W     = $clog2(DEPTH);
  localparam logic [63:0]           BASE_EXT  = 64'(BASE_ADDR);
  localparam logic [63:0]           DEPTH_EXT = 64'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(NB);
  localparam logic [3:0]            WAIT_LAST = (RD_LATENCY == 0) ? 4'd0 : 4'(RD_LATENCY - 1);

  // write channel state
  w_state_t              w_state_r;
  logic [ADDR_WIDTH-1:0] w_addr_r;
  logic [7:0]            w_len_r;
  logic [7:0]            w_beat_r;
  logic                  w_err_r;
  logic                  awready_r;
  logic                  wready_r;
  logic                  bvalid_r;
  logic [1:0]            bresp_r;

  // read channel state; r_addr_r/r_beat_r track the next beat to be loaded
  r_state_t              r_state_r;
  logic [ADDR_WIDTH-1:0] r_addr_r;
  logic [7:0]            r_len_r;
  logic [7:0]            r_beat_r;
  logic [3:0]            r_wait_r;
  logic                  arready_r;
  logic                  rvalid_r;
  logic                  rlast_r;
  logic [1:0]            rresp_r;
  logic [DATA_WIDTH-1:0] rdata_r;

  logic [63:0]           w_idx_s;
  logic                  w_in_range_s;
  logic                  w_fire_s;
  logic                  w_last_beat_s;
  logic                  w_err_next_s;
  logic                  we_s;
  logic [ADDR_WIDTH-1:0] r_lookup_s;
  logic [ADDR_WIDTH-1:0] r_next_addr_s;
  logic [63:0]           r_idx_s;
  logic                  r_in_range_s;
  logic                  r_load_last_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;
  logic [DATA_WIDTH-1:0] r_beat_data_s;
  logic                  unused_idx_s;

  // Write-beat decode: index, range, handshake and error accumulation.
  always_comb begin
    w_idx_s       = addr_to_index(64'(w_addr_r), BASE_EXT, NB_LOG2);
    w_in_range_s  = beat_in_range(64'(w_addr_r), BASE_EXT, NB_LOG2, DEPTH_EXT);
    w_fire_s      = (w_state_r == W_DATA) && s_axi_wvalid && wready_r;
    w_last_beat_s = (w_beat_r == w_len_r);
    we_s          = w_fire_s && w_in_range_s;
    w_err_next_s  = w_err_r | ~w_in_range_s | (w_last_beat_s ? ~s_axi_wlast : s_axi_wlast);
  end

  // Read lookup: in R_IDLE the AR address feeds the array so zero-latency reads load beat 0 directly.
  always_comb begin
    if (r_state_r == R_IDLE) begin
      r_lookup_s    = s_axi_araddr;
      r_load_last_s = (s_axi_arlen == 8'd0);
    end else begin
      r_lookup_s    = r_addr_r;
      r_load_last_s = (r_beat_r == r_len_r);
    end
    r_next_addr_s = r_lookup_s + ADDR_STEP;
    r_idx_s       = addr_to_index(64'(r_lookup_s), BASE_EXT, NB_LOG2);
    r_in_range_s  = beat_in_range(64'(r_lookup_s), BASE_EXT, NB_LOG2, DEPTH_EXT);
    r_beat_data_s = r_in_range_s ? mem_rdata_s : {DATA_WIDTH{1'b0}};
  end

  assign unused_idx_s = ^{w_idx_s[63:IDX_W], r_idx_s[63:IDX_W]};

  axi4_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we_s),
    .waddr (w_idx_s[IDX_W-1:0]),
    .wdata (s_axi_wdata),
    .wstrb (s_axi_wstrb),
    .raddr (r_idx_s[IDX_W-1:0]),
    .rdata (mem_rdata_s)
  );

  // Write FSM: AW accept, W beats with strobes and WLAST checking, then B response.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_r <= W_IDLE;
      w_addr_r  <= {ADDR_WIDTH{1'b0}};
      w_len_r   <= 8'd0;
      w_beat_r  <= 8'd0;
      w_err_r   <= 1'b0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (s_axi_awvalid && awready_r) begin
            w_addr_r  <= s_axi_awaddr;
            w_len_r   <= s_axi_awlen;
            w_beat_r  <= 8'd0;
            w_err_r   <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
            w_state_r <= W_DATA;
          end else begin
            awready_r <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire_s) begin
            w_addr_r <= w_addr_r + ADDR_STEP;
            w_beat_r <= w_beat_r + 8'd1;
            w_err_r  <= w_err_next_s;
            if (w_last_beat_s) begin
              wready_r  <= 1'b0;
              bvalid_r  <= 1'b1;
              bresp_r   <= w_err_next_s ? RESP_SLVERR : RESP_OKAY;
              w_state_r <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            awready_r <= 1'b1;
            w_state_r <= W_IDLE;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
          bresp_r   <= RESP_OKAY;
        end
      endcase
    end
  end

  // Read FSM: AR accept, latency wait, then beats loaded into the R register on each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_r <= R_IDLE;
      r_addr_r  <= {ADDR_WIDTH{1'b0}};
      r_len_r   <= 8'd0;
      r_beat_r  <= 8'd0;
      r_wait_r  <= 4'd0;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rresp_r   <= RESP_OKAY;
      rdata_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (s_axi_arvalid && arready_r) begin
            arready_r <= 1'b0;
            r_len_r   <= s_axi_arlen;
            r_wait_r  <= 4'd0;
            if (RD_LATENCY == 0) begin
              rdata_r   <= r_beat_data_s;
              rresp_r   <= r_in_range_s ? RESP_OKAY : RESP_SLVERR;
              rlast_r   <= r_load_last_s;
              r_beat_r  <= 8'd1;
              r_addr_r  <= r_next_addr_s;
              rvalid_r  <= 1'b1;
              r_state_r <= R_DATA;
            end else begin
              r_addr_r  <= s_axi_araddr;
              r_beat_r  <= 8'd0;
              r_state_r <= R_WAIT;
            end
          end else begin
            arready_r <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_wait_r == WAIT_LAST) begin
            rdata_r   <= r_beat_data_s;
            rresp_r   <= r_in_range_s ? RESP_OKAY : RESP_SLVERR;
            rlast_r   <= r_load_last_s;
            r_beat_r  <= r_beat_r + 8'd1;
            r_addr_r  <= r_next_addr_s;
            rvalid_r  <= 1'b1;
            r_state_r <= R_DATA;
          end else begin
            r_wait_r <= r_wait_r + 4'd1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (rlast_r) begin
              rvalid_r  <= 1'b0;
              rlast_r   <= 1'b0;
              rresp_r   <= RESP_OKAY;
              rdata_r   <= {DATA_WIDTH{1'b0}};
              arready_r <= 1'b1;
              r_state_r <= R_IDLE;
            end else begin
              rdata_r  <= r_beat_data_s;
              rresp_r  <= r_in_range_s ? RESP_OKAY : RESP_SLVERR;
              rlast_r  <= r_load_last_s;
              r_beat_r <= r_beat_r + 8'd1;
              r_addr_r <= r_next_addr_s;
            end
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arready_r <= 1'b0;
          rvalid_r  <= 1'b0;
          rlast_r   <= 1'b0;
          rresp_r   <= RESP_OKAY;
        end
      endcase
    end
  end

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;
  assign s_axi_rlast   = rlast_r;

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Scoreboard bench for axi4_burst_mem_slave: a word model predicts B and R beats, a negedge monitor compares.
module tb_axi4_burst_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = 32'd0;
  logic [7:0]  awlen = 8'd0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        wlast = 1'b0;
  logic        bvalid, bready = 1'b1;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = 32'd0;
  logic [7:0]  arlen = 8'd0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  axi4_burst_mem_slave dut (
    .clk(clk), .rst(rst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast), .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t      rq[$];
  logic [1:0]  bq[$];
  logic [31:0] model [4096];
  logic [31:0] wbuf [256];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        mon_quiet = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: every valid R/B cycle is compared to the scoreboard head; popped on handshake.
  always @(negedge clk) begin
    if (!mon_quiet && rvalid) begin
      if (rq.size() == 0) begin
        check_eq("r_unexpected", 64'(rvalid), 64'd0);
      end else begin
        check_eq("rdata", 64'(rdata), 64'(rq[0].data));
        check_eq("rresp", 64'(rresp), 64'(rq[0].resp));
        check_eq("rlast", 64'(rlast), 64'(rq[0].last));
        if (rready) void'(rq.pop_front());
      end
    end
    if (!mon_quiet && bvalid && bready) begin
      if (bq.size() == 0) begin
        check_eq("b_unexpected", 64'(bvalid), 64'd0);
      end else begin
        check_eq("bresp", 64'(bresp), 64'(bq[0]));
        void'(bq.pop_front());
      end
    end
  end

  // wlast is driven only on beat wlast_at (pass len for a well-formed burst).
  task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] strb, input int wlast_at);
    bit err = 1'b0;
    bit got;
    int t;
    for (int k = 0; k <= len; k++) begin
      int idx = int'(addr >> 2) + k;
      if (idx < 4096) begin
        for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = wbuf[k][b*8 +: 8];
      end else begin
        err = 1'b1;
      end
      if ((k == len) != (k == wlast_at)) err = 1'b1;
    end
    bq.push_back(err ? 2'b10 : 2'b00);
    @(posedge clk); #1;
    awvalid = 1'b1; awaddr = addr; awlen = 8'(len);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready) begin got = 1'b1; break; end
    end
    if (!got) check_eq("aw_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      wvalid = 1'b1; wdata = wbuf[k]; wstrb = strb; wlast = (k == wlast_at);
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (wready) begin got = 1'b1; break; end
      end
      if (!got) check_eq("w_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    t = 0;
    while (bq.size() != 0 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (bq.size() != 0) begin
      check_eq("b_timeout", 64'(bq.size()), 64'd0);
      bq.delete();
    end
  endtask

  // Pushes the first n_exp expected beats, issues AR, then runs until those beats are consumed.
  task automatic do_read(input logic [31:0] addr, input int len, input bit stall, input int n_exp, input bit chk_lat);
    bit got;
    int n;
    int t;
    for (int k = 0; k < n_exp; k++) begin
      rbeat_t e;
      int idx = int'(addr >> 2) + k;
      e.data = (idx < 4096) ? model[idx] : 32'd0;
      e.resp = (idx < 4096) ? 2'b00 : 2'b10;
      e.last = (k == len);
      rq.push_back(e);
    end
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = addr; arlen = 8'(len); rready = !stall;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin got = 1'b1; break; end
    end
    if (!got) check_eq("ar_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (chk_lat) begin
      n = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk); n++;
        if (rvalid) break;
      end
      check_eq("rd_latency", 64'(n), 64'd3);
    end
    t = 0;
    while (rq.size() != 0 && t < 400) begin
      @(posedge clk); #1;
      if (stall) rready = ~rready;
      t++;
    end
    if (rq.size() != 0) begin
      check_eq("r_timeout", 64'(rq.size()), 64'd0);
      rq.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_awready", 64'(awready), 64'd0);
    check_eq("rst_arready", 64'(arready), 64'd0);
    check_eq("rst_bvalid",  64'(bvalid),  64'd0);
    check_eq("rst_rvalid",  64'(rvalid),  64'd0);
    check_eq("rst_rdata",   64'(rdata),   64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("post_rst_awready", 64'(awready), 64'd1);
    check_eq("post_rst_arready", 64'(arready), 64'd1);

    // single beat with latency check
    wbuf[0] = 32'hDEAD_BEEF;
    do_write(32'h10, 0, 4'hF, 0);
    do_read(32'h10, 0, 1'b0, 1, 1'b1);

    // 16-beat burst, read back with rready toggling
    for (int k = 0; k < 16; k++) wbuf[k] = 32'(k);
    do_write(32'h100, 15, 4'hF, 15);
    do_read(32'h100, 15, 1'b1, 16, 1'b0);

    // byte strobes
    wbuf[0] = 32'hFFFF_FFFF;
    do_write(32'h200, 0, 4'hF, 0);
    wbuf[0] = 32'h0000_0000;
    do_write(32'h200, 0, 4'h5, 0);
    do_read(32'h200, 0, 1'b0, 1, 1'b0);

    // burst running off the end of memory
    wbuf[0] = 32'hA5A5_1234;
    wbuf[1] = 32'h5555_5555;
    do_write(32'h3FFC, 1, 4'hF, 1);
    do_read(32'h3FFC, 1, 1'b0, 2, 1'b0);

    // early and missing WLAST
    for (int k = 0; k < 4; k++) wbuf[k] = 32'hC0DE_0000 + 32'(k);
    do_write(32'h300, 3, 4'hF, 2);
    do_read(32'h300, 3, 1'b0, 4, 1'b0);
    for (int k = 0; k < 4; k++) wbuf[k] = 32'hBEEF_0000 + 32'(k);
    do_write(32'h300, 3, 4'hF, 99);
    do_read(32'h300, 3, 1'b0, 4, 1'b0);

    // reset after 3 beats of an 8-beat read
    do_read(32'h100, 7, 1'b0, 3, 1'b0);
    mon_quiet = 1'b1;
    rst = 1'b1;
    rready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst_rvalid", 64'(rvalid), 64'd0);
    check_eq("mid_rst_rlast",  64'(rlast),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_quiet = 1'b0;
    do_read(32'h100, 15, 1'b0, 16, 1'b0);
    do_read(32'h10, 0, 1'b0, 1, 1'b0);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
